cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 block for the exception-capable five-stage MIPS pipeline. It consumes the M-stage exception bundle (PC, branch-delay flag, ExcCode) carried by the EX/MEM pipeline register, together with the six hardware interrupt lines. It decides whether to take an exception or interrupt, records SR/Cause/EPC, and drives the `IntReq` pulse. `IntReq` flushes every pipeline register and redirects fetch to the handler. It also services `mfc0`/`mtc0` and `eret`.

## Interface
Parameters:
- `PRID`, default 32'h2020_0007: read-only processor ID value.
- `HANDLER`, default 32'h0000_4180: exception entry address, exported on `HandlerPC`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (state cleared on the rising edge while `reset`==0).
- `A1`  in  5  CP0 register number read by `mfc0`.
- `A2`  in  5  CP0 register number written by `mtc0`.
- `DIn`  in  32  `mtc0` write data.
- `WE`  in  1  `mtc0` write enable (M stage).
- `PCM`  in  32  PC of the instruction currently in M.
- `BDM`  in  1  M instruction sits in a branch delay slot.
- `ExcCodeM`  in  5 ([6:2])  pending exception code of the M instruction; 0 = none.
- `HWInt`  in  6 ([7:2])  external interrupt lines, level-sensitive.
- `EXLClr`  in  1  `eret` in M.
- `IntReq`  out  1  take exception/interrupt this cycle (combinational).
- `EPC`  out  32  current EPC register.
- `DOut`  out  32  `mfc0` read data (combinational from `A1`).
- `HandlerPC`  out  32  constant `HANDLER`.

## Operation
- Registers:
  - SR (#12): IM[15:10], EXL[1], IE[0].
  - Cause (#13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC (#14): full 32 bits.
  - PrID (#15) = `PRID`.
  - All other bits read 0. Other register numbers read 0.
- `IntPend` = |(`HWInt` & IM) & IE & !EXL.
- `ExcPend` = (`ExcCodeM`!=0) & !EXL.
- `IntReq` = `IntPend` | `ExcPend`.
- On an `IntReq` edge:
  - EXL←1.
  - BD←`BDM`.
  - ExcCode←0 when `IntPend` (an interrupt wins over a simultaneous exception), else ←`ExcCodeM`.
  - EPC←(`BDM` ? `PCM`−4 : `PCM`) & ~32'h3.
- IP←`HWInt` every cycle, unconditionally, including the `IntReq` cycle.
- `mtc0` (`WE`=1, `IntReq`=0):
  - #12 writes IM/EXL/IE from `DIn`.
  - #14 writes EPC←`DIn`.
  - Writes to #13, #15 and all other numbers are ignored.
- `WE` with `IntReq`=1: the write is dropped, because the faulting or interrupted instruction must not commit.
- `EXLClr` with `IntReq`=0: EXL←0. `EXLClr` and `IntReq` cannot both be effective, since EXL=1 masks `IntReq` during `eret`. If both are asserted, the `IntReq` update wins.
- Priority on the same edge: reset > `IntReq` > `EXLClr` > `mtc0`.

## Timing
- Reset values: SR=0, Cause=0, EPC=0. After reset `DOut` reads 0 for #12, #13 and #14.
- `IntReq` is asserted whenever `ExcCodeM`!=0, even with IE=0, because exceptions are not maskable. It is deasserted only while EXL=1.
- `IntReq`, `DOut` and `EPC` are combinational from current state and inputs. The state update is visible the cycle after the edge.
- `mtc0` then `mfc0` of the same register in the following cycle returns the new value. There is no same-cycle bypass, so a same-cycle read returns the old value.
- Once EXL is set, `IntReq` drops on the next cycle and no nested exception is taken until `eret`.
- Reset mid-exception (`reset`=0 on the same edge as `IntReq`=1): the reset values win.

## Structure
- Shared package constants:
  - Register numbers: `CP0_SR`=12, `CP0_CAUSE`=13, `CP0_EPC`=14, `CP0_PRID`=15.
  - ExcCodes: `EXC_INT`=0, `EXC_ADEL`=4, `EXC_ADES`=5, `EXC_RI`=10, `EXC_OV`=12.
  - The `HANDLER` default value.
- Single flat module; no sub-module.

## Test plan
- Reset, then read #12/#13/#14/#15 → 0, 0, 0, `PRID`; `IntReq`=0.
- `mtc0` #12 ← 32'h0000_FC01, then `HWInt`=6'b000100 with `PCM`=32'h3010, `BDM`=0 → `IntReq`=1 for one cycle; after the edge EXL=1, ExcCode=0, IP=6'b000100, EPC=32'h3010.
- `ExcCodeM`=12 (Ov) with IE=0, `PCM`=32'h3024, `BDM`=1 → `IntReq`=1; Cause reads 32'h8000_0030 (BD=1, ExcCode=12); EPC=32'h3020.
- Same cycle: `HWInt` enabled and `ExcCodeM`=4 → ExcCode=0 (interrupt wins); a concurrent `mtc0` #14 ← 32'hDEAD_BEE0 leaves EPC=`PCM`.
- With EXL=1 apply `ExcCodeM`=10 → `IntReq`=0; then `EXLClr`=1 → EXL=0 next cycle, and the still-pending `HWInt` raises `IntReq` on the following cycle.
- `reset`=0 asserted while `IntReq`=1 → SR/Cause/EPC all 0 after the edge.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// cp0_unit shared constants: CP0 register numbers,
// exception codes and default parameter values.
package cp0_unit_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] PRID_DEF    = 32'h2020_0007;
  localparam logic [31:0] HANDLER_DEF = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PrID, exception and
// interrupt arbitration, mfc0/mtc0 and eret support.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID    = PRID_DEF,
  parameter logic [31:0] HANDLER = HANDLER_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic [6:2]  ExcCodeM,
  input  logic [7:2]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut,
  output logic [31:0] HandlerPC
);

  logic [5:0]  im;
  logic [5:0]  ip;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exc;
  logic [31:0] epc_q;

  logic        int_pend;
  logic        exc_pend;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] epc_exc;
  logic        unused_din;

  assign int_pend = (|(HWInt & im)) & ie & ~exl;
  assign exc_pend = (ExcCodeM != 5'd0) & ~exl;
  assign IntReq   = int_pend | exc_pend;

  assign wr_sr  = WE & (A2 == CP0_SR);
  assign wr_epc = WE & (A2 == CP0_EPC);

  // Restart point: a delay-slot fault resumes at its branch
  assign epc_exc = (BDM ? PCM - 32'd4 : PCM) & ~32'h3;

  assign EPC        = epc_q;
  assign HandlerPC  = HANDLER;
  assign unused_din = ^{DIn[31:16], DIn[9:2]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      im    <= '0;
      ip    <= '0;
      exl   <= 1'b0;
      ie    <= 1'b0;
      bd    <= 1'b0;
      exc   <= '0;
      epc_q <= '0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl   <= 1'b1;
        bd    <= BDM;
        exc   <= int_pend ? EXC_INT : ExcCodeM;
        epc_q <= epc_exc;
      end else begin
        if (wr_sr) begin
          im <= DIn[15:10];
          ie <= DIn[0];
        end
        if (EXLClr)
          exl <= 1'b0;
        else if (wr_sr)
          exl <= DIn[1];
        if (wr_epc)
          epc_q <= DIn;
      end
    end
  end

  always_comb begin
    DOut = '0;
    unique case (1'b1)
      (A1 == CP0_SR):
        DOut = {16'b0, im, 8'b0, exl, ie};
      (A1 == CP0_CAUSE):
        DOut = {bd, 15'b0, ip, 3'b0, exc, 2'b0};
      (A1 == CP0_EPC):
        DOut = epc_q;
      (A1 == CP0_PRID):
        DOut = PRID;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed and random checks of cp0_unit against a
// register-image reference model.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2020_0007;
  localparam logic [31:0] HNDL = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PCM;
  logic        BDM;
  logic [4:0]  ExcCodeM;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC, DOut, HandlerPC;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  always #5 clk = ~clk;

  cp0_unit #(.PRID(PRID), .HANDLER(HNDL)) dut (
    .clk(clk), .reset(reset),
    .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PCM(PCM), .BDM(BDM), .ExcCodeM(ExcCodeM),
    .HWInt(HWInt), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC), .DOut(DOut),
    .HandlerPC(HandlerPC)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic m_int();
    int en;
    en = int'(HWInt) & int'(m_sr[15:10]);
    return (en != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_irq();
    return m_int() || (ExcCodeM != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(
    input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  // Compare outputs to the model, then advance one edge.
  task automatic step();
    logic [31:0] ns, nc, ne;
    logic [31:0] code;
    #1;
    check("intreq", {31'b0, IntReq}, {31'b0, m_irq()});
    check("dout", DOut, m_read(A1));
    check("epc", EPC, m_epc);
    ns = m_sr;
    ne = m_epc;
    nc = (m_cause & ~32'h0000_FC00)
       | (32'(HWInt) << 10);
    if (m_irq()) begin
      code = m_int() ? 0 : 32'(ExcCodeM);
      ns = ns | 32'h2;
      nc = (nc & 32'h0000_FC00)
         | (32'(BDM) << 31) | (code << 2);
      ne = (BDM ? PCM - 4 : PCM) & ~32'h3;
    end else begin
      if (WE && A2 == 12) ns = DIn & 32'h0000_FC03;
      if (WE && A2 == 14) ne = DIn;
      if (EXLClr) ns = ns & ~32'h2;
    end
    if (!reset) begin
      ns = 0; nc = 0; ne = 0;
    end
    @(posedge clk);
    m_sr = ns; m_cause = nc; m_epc = ne;
    #1;
  endtask

  initial begin
    reset = 1'b0; A1 = 0; A2 = 0; DIn = 0; WE = 0;
    PCM = 0; BDM = 0; ExcCodeM = 0; HWInt = 0;
    EXLClr = 0;
    repeat (2) @(posedge clk);
    #1;
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b1;

    A1 = 12; #1;
    check("rst_sr", DOut, 32'h0);
    check("rst_irq", {31'b0, IntReq}, 32'h0);
    check("handler", HandlerPC, HNDL);
    step();
    A1 = 13; #1; check("rst_cause", DOut, 32'h0); step();
    A1 = 14; #1; check("rst_epc", DOut, 32'h0); step();
    A1 = 15; #1; check("prid", DOut, PRID); step();

    WE = 1; A2 = 12; DIn = 32'h0000_FC01; step();
    WE = 0; HWInt = 6'b000100; PCM = 32'h3010;
    BDM = 0; A1 = 12; #1;
    check("int_req", {31'b0, IntReq}, 32'h1);
    step();
    #1;
    check("int_drop", {31'b0, IntReq}, 32'h0);
    check("int_sr", DOut, 32'h0000_FC03);
    A1 = 13; #1;
    check("int_cause", DOut, 32'h0000_1000);
    check("int_epc", EPC, 32'h0000_3010);
    step();

    WE = 1; A2 = 12; DIn = 32'h0; HWInt = 0; step();
    WE = 0; ExcCodeM = 12; PCM = 32'h3024; BDM = 1; #1;
    check("ov_req", {31'b0, IntReq}, 32'h1);
    step();
    ExcCodeM = 0; BDM = 0; A1 = 13; #1;
    check("ov_cause", DOut, 32'h8000_0030);
    check("ov_epc", EPC, 32'h0000_3020);
    step();

    WE = 1; A2 = 12; DIn = 32'h0000_FC01; step();
    A2 = 14; DIn = 32'hDEAD_BEE0; HWInt = 6'b000001;
    ExcCodeM = 4; PCM = 32'h3040; #1;
    check("both_req", {31'b0, IntReq}, 32'h1);
    step();
    WE = 0; ExcCodeM = 0; A1 = 13; #1;
    check("both_cause", DOut, 32'h0000_0400);
    check("both_epc", EPC, 32'h0000_3040);
    step();

    ExcCodeM = 10; #1;
    check("exl_mask", {31'b0, IntReq}, 32'h0);
    step();
    ExcCodeM = 0; EXLClr = 1; #1;
    check("eret_irq", {31'b0, IntReq}, 32'h0);
    step();
    EXLClr = 0; A1 = 12; #1;
    check("eret_sr", DOut, 32'h0000_FC01);
    check("repend", {31'b0, IntReq}, 32'h1);
    reset = 0; step();
    reset = 1; HWInt = 0; #1;
    check("mid_sr", DOut, 32'h0);
    A1 = 13; #1; check("mid_cause", DOut, 32'h0);
    A1 = 14; #1; check("mid_epc", DOut, 32'h0);
    step();

    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 49) != 0);
      A1     = 5'($urandom_range(10, 16));
      A2     = 5'($urandom_range(11, 16));
      DIn    = $urandom;
      WE     = ($urandom_range(0, 2) == 0);
      PCM    = $urandom;
      BDM    = 1'($urandom);
      HWInt  = 6'($urandom);
      EXLClr = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0: ExcCodeM = 5'd4;
        1: ExcCodeM = 5'd5;
        2: ExcCodeM = 5'd10;
        3: ExcCodeM = 5'($urandom);
        default: ExcCodeM = 5'd0;
      endcase
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
